loop_invoker: RTL and testbench

//   Initiator side of the go/done handshake that generated FSMs expose. Accepts a

---
 rtl/loop_invoker_pkg.sv | 17 +
 rtl/loop_invoker_watchdog.sv | 29 ++
 rtl/loop_invoker.sv | 113 +++++++++++
 tb/tb_loop_invoker.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/loop_invoker_pkg.sv
// Shared state encoding for loop_invoker and the generated child FSMs.
// The encodings are exported as localparams so child FSMs can decode them without the enum.
package loop_invoker_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        LAUNCH = ST_LAUNCH,
        WAIT   = ST_WAIT,
        FINISH = ST_FINISH
    } state_t;

endpackage

// File: rtl/loop_invoker_watchdog.sv
// loop_watchdog: counts cycles while not cleared and flags expiry at TIMEOUT_CYCLES.
// Only instantiated by loop_invoker when LOOP_INVOKER_TIMEOUT_EN is defined.
module loop_watchdog #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_cnt;

    // expire is asserted during the TIMEOUT_CYCLES-th counted cycle; the count then saturates
    assign expire = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (!expire) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/loop_invoker.sv
// loop_invoker: issues trip_count go/done handshakes to a child FSM, then pulses done.
// Optional WAIT timeout with err flag enabled by defining LOOP_INVOKER_TIMEOUT_EN.
module loop_invoker
    import loop_invoker_pkg::*;
#(
    parameter int CNT_W          = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [CNT_W-1:0] trip_count,
    output logic             child_go,
    input  logic             child_done,
    output logic [CNT_W-1:0] iter,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           r_state;
    logic [CNT_W-1:0] r_trips;
    logic [CNT_W-1:0] r_iter;
    logic             r_err;

    state_t           w_state_next;
    logic [CNT_W-1:0] w_trips_next;
    logic [CNT_W-1:0] w_iter_next;
    logic             w_err_next;
    logic             w_last;
    logic             w_expire;

    if (CNT_W < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("loop_invoker: CNT_W and TIMEOUT_CYCLES must be at least 1");
    end

`ifdef LOOP_INVOKER_TIMEOUT_EN
    // Watchdog is held clear outside WAIT, so it restarts on every entry to WAIT
    loop_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .clear (r_state != WAIT),
        .expire(w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    // Termination compares against trips-1, so iter never has to count past the last index
    assign w_last = (r_iter == (r_trips - CNT_W'(1)));

    always_comb begin
        w_state_next = r_state;
        w_trips_next = r_trips;
        w_iter_next  = r_iter;
        w_err_next   = r_err;
        case (r_state)
            IDLE: begin
                if (go) begin
                    w_trips_next = trip_count;
                    w_iter_next  = '0;
                    w_err_next   = 1'b0;
                    w_state_next = (trip_count != '0) ? LAUNCH : FINISH;
                end
            end
            LAUNCH: begin
                w_state_next = WAIT;
            end
            WAIT: begin
                if (child_done) begin
                    if (w_last) begin
                        w_state_next = FINISH;
                    end else begin
                        w_iter_next  = r_iter + CNT_W'(1);
                        w_state_next = LAUNCH;
                    end
                end else if (w_expire) begin
                    w_err_next   = 1'b1;
                    w_state_next = FINISH;
                end
            end
            FINISH: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_trips <= '0;
            r_iter  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_trips <= w_trips_next;
            r_iter  <= w_iter_next;
            r_err   <= w_err_next;
        end
    end

    assign child_go = (r_state == LAUNCH);
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == FINISH);
    assign iter     = r_iter;
    assign err      = r_err;

endmodule

// File: tb/tb_loop_invoker.sv
// Directed testbench for loop_invoker; cycle c counts from the edge that samples go (c=0).
// Build with LOOP_INVOKER_TIMEOUT_EN to exercise the timeout path (TIMEOUT_CYCLES=4).
module tb_loop_invoker;

    logic       clk = 1'b0;
    logic       reset;
    logic       go;
    logic [3:0] trip_count;
    logic       child_go;
    logic       child_done;
    logic [3:0] iter;
    logic       busy;
    logic       done;
    logic       err;

    int checks   = 0;
    int failures = 0;

    loop_invoker #(
        .CNT_W         (4),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .go        (go),
        .trip_count(trip_count),
        .child_go  (child_go),
        .child_done(child_done),
        .iter      (iter),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int c, input bit e_go, input bit e_busy,
                            input bit e_done, input int e_iter, input bit e_err);
        chk({tag, ".child_go"}, c, 32'(child_go), 32'(e_go));
        chk({tag, ".busy"},     c, 32'(busy),     32'(e_busy));
        chk({tag, ".done"},     c, 32'(done),     32'(e_done));
        chk({tag, ".iter"},     c, 32'(iter),     32'(e_iter));
        chk({tag, ".err"},      c, 32'(err),      32'(e_err));
        $display("%s c=%0d go=%0b tc=%0d cdone=%0b -> child_go=%0b busy=%0b done=%0b iter=%0d err=%0b",
                 tag, c, go, trip_count, child_done, child_go, busy, done, iter, err);
    endtask

    initial begin
        reset      = 1'b1;
        go         = 1'b0;
        trip_count = '0;
        child_done = 1'b0;
        #2;
        chk_outs("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // trip_count=3, L=2: child_go at 1,4,7; done at 10; busy 1..10
        for (int c = 0; c <= 11; c++) begin
            go         = (c == 0);
            trip_count = 4'd3;
            child_done = (c == 3 || c == 6 || c == 9);
            chk_outs("trips3", c, (c == 1 || c == 4 || c == 7), (c >= 1 && c <= 10), (c == 10),
                     (c <= 3) ? 0 : (c <= 6) ? 1 : 2, 0);
            tick();
        end

        // trip_count=0: done/busy only in cycle 1; iter from previous run cleared by the go
        for (int c = 0; c <= 2; c++) begin
            go         = (c == 0);
            trip_count = 4'd0;
            child_done = 1'b0;
            chk_outs("trips0", c, 0, (c == 1), (c == 1), (c == 0) ? 2 : 0, 0);
            tick();
        end

        // go and trip_count changes while busy are ignored
        for (int c = 0; c <= 5; c++) begin
            go         = (c <= 3);
            trip_count = (c == 0) ? 4'd1 : 4'd7;
            child_done = (c == 2);
            chk_outs("busygo", c, (c == 1), (c >= 1 && c <= 3), (c == 3), 0, 0);
            tick();
        end
        go = 1'b0;

        // trip_count=4, L=2, async reset during WAIT of trip 1
        for (int c = 0; c <= 5; c++) begin
            go         = (c == 0);
            trip_count = 4'd4;
            child_done = (c == 3);
            chk_outs("prerst", c, (c == 1 || c == 4), (c >= 1), 0, (c <= 3) ? 0 : 1, 0);
            if (c < 5) tick();
        end
        child_done = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk_outs("midrst", 5, 0, 0, 0, 0, 0);
        #1;
        reset = 1'b0;
        tick();

        // clean restart after reset: trip_count=2, L=1, done at 5
        for (int c = 0; c <= 6; c++) begin
            go         = (c == 0);
            trip_count = 4'd2;
            child_done = (c == 2 || c == 4);
            chk_outs("postrst", c, (c == 1 || c == 3), (c >= 1 && c <= 5), (c == 5), (c >= 3) ? 1 : 0, 0);
            tick();
        end

        // child_done held high in IDLE, LAUNCH, FINISH and after: only WAIT samples it
        for (int c = 0; c <= 10; c++) begin
            go         = (c == 1);
            trip_count = 4'd2;
            child_done = (c <= 2 || c == 5 || c >= 7);
            chk_outs("stale", c, (c == 2 || c == 6), (c >= 2 && c <= 8), (c == 8),
                     (c <= 1 || c >= 6) ? 1 : 0, 0);
            tick();
        end
        child_done = 1'b0;

`ifdef LOOP_INVOKER_TIMEOUT_EN
        // child never answers: FINISH with err after 4 WAIT cycles; err clears on next go
        for (int c = 0; c <= 11; c++) begin
            go         = (c == 0 || c == 7);
            trip_count = (c == 7) ? 4'd1 : 4'd2;
            child_done = (c == 9);
            chk_outs("timeout", c, (c == 1 || c == 8), ((c >= 1 && c <= 6) || (c >= 8 && c <= 10)),
                     (c == 6 || c == 10), (c == 0) ? 1 : 0, (c == 6 || c == 7));
            tick();
        end
`else
        // without the timeout, WAIT holds for as long as the child takes
        for (int c = 0; c <= 21; c++) begin
            go         = (c == 0);
            trip_count = 4'd1;
            child_done = (c == 19);
            chk_outs("nowdog", c, (c == 1), (c >= 1 && c <= 20), (c == 20), (c == 0) ? 1 : 0, 0);
            tick();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
